// File: rtl/program_counter_stack.sv
// rtl/program_counter_stack.sv - program counter with bus tristate, call/return stack and sticky fault flag
// Optional relative jump: define PC_REL_JMP_EN.
module program_counter_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             ce,
    input  logic             updown,
    input  logic             co,
    input  logic             jmp,
    input  logic             rel,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   sp_m1;
    logic [WIDTH-1:0] stack [2**IW];
    logic             push;

    assign bus   = co ? pc : {WIDTH{1'bz}};
    assign full  = (sp == SP_FULL);
    assign empty = (sp == '0);
    assign sp_m1 = sp - 1'b1;
    assign push  = !rst && call && !full;

    // Stack storage has no reset; stale entries are unreachable once sp is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[sp[IW-1:0]] <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= '0;
            sp  <= '0;
            err <= 1'b0;
        end else if (call) begin
            if (full) begin
                err <= 1'b1;
            end else begin
                sp <= sp + 1'b1;
                pc <= bus;
            end
        end else if (ret) begin
            if (empty) begin
                err <= 1'b1;
            end else begin
                sp <= sp_m1;
                pc <= stack[sp_m1[IW-1:0]];
            end
        end else if (jmp) begin
`ifdef PC_REL_JMP_EN
            // bus is a two's-complement offset; modulo wrap falls out of the add.
            if (rel) begin
                pc <= pc + bus;
            end else begin
                pc <= bus;
            end
`else
            pc <= bus;
`endif
        end else if (ce) begin
            if (updown) begin
                pc <= pc + 1'b1;
            end else begin
                pc <= pc - 1'b1;
            end
        end
    end

`ifndef PC_REL_JMP_EN
    logic unused_rel;
    assign unused_rel = rel;
`endif

endmodule

// File: tb/tb_program_counter_stack.sv
// tb/tb_program_counter_stack.sv - directed self-checking bench for program_counter_stack
module tb_program_counter_stack;

    logic       clk = 1'b0;
    logic       rst, ce, updown, co, jmp, rel, call, ret;
    logic [7:0] tb_bus;
    logic       tb_drv;
    wire  [7:0] bus;
    logic [7:0] pc;
    logic       full, empty, err;
    int         checks = 0;
    int         errors = 0;

    assign bus = tb_drv ? tb_bus : 8'bzzzzzzzz;

    program_counter_stack #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ce(ce), .updown(updown), .co(co),
        .jmp(jmp), .rel(rel), .call(call), .ret(ret), .pc(pc),
        .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; ce = 0; updown = 1; co = 0; jmp = 0; rel = 0; call = 0; ret = 0;
        tb_drv = 1; tb_bus = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_rel;
        idle();
        rst = 1;
        step();
        chk("reset_pc", pc, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_err", err, 0);

        // Free-running up-count across the wrap; bus must carry only the bench's value.
        idle();
        ce = 1; updown = 1; tb_bus = 8'hA5;
        for (int i = 1; i <= 257; i++) begin
            step();
            chk("count_up_pc", pc, i % 256);
            chk("count_up_bus_released", bus, 8'hA5);
        end

        idle(); rst = 1; step();
        idle(); ce = 1; updown = 0; step();
        chk("count_down_wrap", pc, 8'hFF);
        idle(); tb_drv = 0; co = 1; #1;
        chk("co_bus_same_cycle", bus, 8'hFF);

        idle(); jmp = 1; tb_bus = 8'h10; step();
        chk("jmp_abs", pc, 8'h10);
        idle(); call = 1; tb_bus = 8'h40; step();
        chk("call_pc", pc, 8'h40);
        chk("call_empty", empty, 0);
        idle(); ret = 1; step();
        chk("ret_pc", pc, 8'h10);
        chk("ret_empty", empty, 1);
        chk("call_ret_err", err, 0);

        // Fill the stack, then overflow with ce asserted too.
        idle(); rst = 1; step();
        for (int k = 1; k <= 4; k++) begin
            idle(); call = 1; tb_bus = 8'(k); step();
            chk("fill_pc", pc, k);
            chk("fill_full", full, (k == 4) ? 1 : 0);
        end
        idle(); call = 1; ce = 1; tb_bus = 8'h55; step();
        chk("overflow_pc", pc, 4);
        chk("overflow_err", err, 1);
        chk("overflow_full", full, 1);
        idle(); ce = 1; step();
        chk("err_sticky_count", pc, 5);
        chk("err_sticky", err, 1);
        for (int k = 3; k >= 0; k--) begin
            idle(); ret = 1; step();
            chk("pop_pc", pc, k);
        end
        chk("pop_empty", empty, 1);
        idle(); rst = 1; step();
        chk("rst_after_err_pc", pc, 0);
        chk("rst_after_err_empty", empty, 1);
        chk("rst_after_err_err", err, 0);

        idle(); ret = 1; ce = 1; step();
        chk("underflow_pc", pc, 0);
        chk("underflow_err", err, 1);

        idle(); rst = 1; step();
        idle(); jmp = 1; tb_bus = 8'h20; step();
        idle(); jmp = 1; rel = 1; tb_bus = 8'hFC; step();
`ifdef PC_REL_JMP_EN
        exp_rel = 8'h1C;
`else
        exp_rel = 8'hFC;
`endif
        chk("jmp_rel", pc, exp_rel);

        idle(); rst = 1; call = 1; ret = 1; jmp = 1; ce = 1; tb_bus = 8'h77; step();
        chk("all_ops_rst_pc", pc, 0);
        chk("all_ops_rst_empty", empty, 1);
        idle(); jmp = 1; tb_bus = 8'h05; step();
        idle(); call = 1; ret = 1; ce = 1; tb_bus = 8'h33; step();
        chk("call_over_ret_pc", pc, 8'h33);
        chk("call_over_ret_empty", empty, 0);
        idle(); ret = 1; step();
        chk("stack_top", pc, 8'h05);

        // Jump and call while the counter drives the bus reload pc unchanged.
        idle(); tb_drv = 0; co = 1; jmp = 1; step();
        chk("jmp_self_bus", pc, 8'h05);
        idle(); tb_drv = 0; co = 1; call = 1; step();
        chk("call_self_bus_pc", pc, 8'h05);
        chk("call_self_bus_empty", empty, 0);

        // Reset between call and ret drops the pending return.
        idle(); rst = 1; step();
        idle(); ret = 1; step();
        chk("rst_discards_ret_pc", pc, 0);
        chk("rst_discards_ret_err", err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
